// File: rtl/conv1d_job_scheduler.sv
// rtl/conv1d_job_scheduler.sv - round-robin job scheduler sharing one conv1d engine
// Optional RUN watchdog abort: define CONV_SCHED_WATCHDOG_EN.
module conv1d_job_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 24,
  parameter int INPUT_LEN   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int RD_WIDTH    = 3,
  parameter int WDOG_CYCLES = 256,
  localparam int OUTPUT_LEN = INPUT_LEN - KERNEL_SIZE + 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_REQ-1:0]            in_ready_o,
  output logic                          res_valid_o,
  output logic [ACCUM_WIDTH-1:0]        res_data_o,
  output logic [ID_W-1:0]               res_id_o,
  output logic                          res_last_o,
  input  logic                          res_ready_i,
  output logic                          busy_o,
  output logic                          eng_start_o,
  input  logic                          eng_done_i,
  output logic                          eng_data_wen_o,
  output logic [ADDR_WIDTH-1:0]         eng_data_addr_o,
  output logic [DATA_WIDTH-1:0]         eng_data_din_o,
  output logic                          eng_weight_wen_o,
  output logic [ADDR_WIDTH-1:0]         eng_weight_addr_o,
  output logic [DATA_WIDTH-1:0]         eng_weight_din_o,
  output logic [RD_WIDTH-1:0]           eng_rd_addr_o,
  input  logic [ACCUM_WIDTH-1:0]        eng_rd_dout_i,
  output logic                          err_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_D, S_LOAD_W, S_START, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [RD_WIDTH-1:0]   idx_q, idx_d;

  logic                  grant_vld;
  logic [ID_W-1:0]       grant_id;
  int                    gnt_j;
  logic                  word_vld;
  logic [DATA_WIDTH-1:0] word;
  logic [ID_W-1:0]       rr_next;

`ifdef CONV_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    gnt_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_j = int'(rr_q) + k;
      if (gnt_j >= NUM_REQ) gnt_j = gnt_j - NUM_REQ;
      if (!grant_vld && in_valid_i[gnt_j]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(gnt_j);
      end
    end
  end

  assign word_vld = in_valid_i[id_q];
  assign word     = in_data_i[id_q*DATA_WIDTH +: DATA_WIDTH];
  assign rr_next  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d           = state_q;
    id_d              = id_q;
    rr_d              = rr_q;
    cnt_d             = cnt_q;
    idx_d             = idx_q;
    in_ready_o        = '0;
    res_valid_o       = 1'b0;
    res_data_o        = '0;
    res_id_o          = '0;
    res_last_o        = 1'b0;
    eng_start_o       = 1'b0;
    eng_data_wen_o    = 1'b0;
    eng_data_addr_o   = '0;
    eng_data_din_o    = '0;
    eng_weight_wen_o  = 1'b0;
    eng_weight_addr_o = '0;
    eng_weight_din_o  = '0;
    eng_rd_addr_o     = '0;
    err_o             = 1'b0;
`ifdef CONV_SCHED_WATCHDOG_EN
    wdog_d            = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          id_d    = grant_id;
          cnt_d   = '0;
          state_d = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        in_ready_o      = NUM_REQ'(1) << id_q;
        eng_data_addr_o = cnt_q;
        if (word_vld) begin
          eng_data_wen_o = 1'b1;
          eng_data_din_o = word;
          if (cnt_q == ADDR_WIDTH'(INPUT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_LOAD_W;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        in_ready_o        = NUM_REQ'(1) << id_q;
        eng_weight_addr_o = cnt_q;
        if (word_vld) begin
          eng_weight_wen_o = 1'b1;
          eng_weight_din_o = word;
          if (cnt_q == ADDR_WIDTH'(KERNEL_SIZE - 1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        eng_start_o = 1'b1;
        state_d     = S_RUN;
`ifdef CONV_SCHED_WATCHDOG_EN
        wdog_d      = '0;
`endif
      end
      S_RUN: begin
        if (eng_done_i) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end
`ifdef CONV_SCHED_WATCHDOG_EN
        // The abort fires in the last permitted RUN cycle, so err lasts one cycle.
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          err_o   = 1'b1;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        eng_rd_addr_o = idx_q;
        res_valid_o   = 1'b1;
        res_data_o    = eng_rd_dout_i;
        res_id_o      = id_q;
        res_last_o    = (idx_q == RD_WIDTH'(OUTPUT_LEN - 1));
        if (res_ready_i) begin
          if (res_last_o) begin
            idx_d   = '0;
            rr_d    = rr_next;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CONV_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`endif

endmodule

// File: tb/tb_conv1d_job_scheduler.sv
// tb/tb_conv1d_job_scheduler.sv - scoreboard bench for conv1d_job_scheduler with an engine model
module tb_conv1d_job_scheduler;
  localparam int NR = 2, DW = 8, AW = 24, IL = 8, KS = 3, OL = 6, ADW = 4, RDW = 3;

  logic           clk, rst_n;
  logic [NR-1:0]  in_valid;
  logic [NR*DW-1:0] in_data;
  logic [NR-1:0]  in_ready;
  logic           res_valid, res_last, res_ready, busy, eng_start, eng_done, err;
  logic [AW-1:0]  res_data;
  logic [0:0]     res_id;
  logic           dwen, wwen;
  logic [ADW-1:0] daddr, waddr;
  logic [DW-1:0]  ddin, wdin;
  logic [RDW-1:0] rd_addr;
  logic [AW-1:0]  rd_dout;
  logic [63:0]    all_out;

  conv1d_job_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_id_o(res_id),
    .res_last_o(res_last), .res_ready_i(res_ready), .busy_o(busy),
    .eng_start_o(eng_start), .eng_done_i(eng_done),
    .eng_data_wen_o(dwen), .eng_data_addr_o(daddr), .eng_data_din_o(ddin),
    .eng_weight_wen_o(wwen), .eng_weight_addr_o(waddr), .eng_weight_din_o(wdin),
    .eng_rd_addr_o(rd_addr), .eng_rd_dout_i(rd_dout), .err_o(err)
  );

  assign all_out = {3'b0, in_ready, res_valid, res_data, res_id, res_last, busy, eng_start,
                    dwen, daddr, ddin, wwen, waddr, wdin, rd_addr, err} >> 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0, checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [0:0]         id;
    logic [7:0][7:0]    d;
    logic [2:0][7:0]    w;
    logic [7:0]         gap_at;
    logic [7:0]         gap_len;
    logic               toggle;
    logic [5:0][23:0]   exp;
  } job_t;

  typedef struct packed {
    logic [0:0]  id;
    logic [23:0] data;
    logic        last;
  } res_t;

  job_t jobs[5];
  res_t sb[$];

  logic [8:0] fbuf[NR][512];
  int         rd_p[NR], wr_p[NR];
  bit         hs[NR];
  bit         toggle_mode;

  logic [7:0]  dmem[16], wmem[16];
  logic [23:0] rmem[8];
  int          eng_timer;
  bit          eng_mute, done_m, force_done;
  int          dcnt, wcnt, starts, exp_starts;
  bit          prev_stall, prev_start;
  logic [27:0] prev_res;

  assign rd_dout  = rmem[rd_addr];
  assign eng_done = done_m | force_done;

  // Requester feeders and res_ready driver; bit 8 of a feed item marks a one-cycle bubble.
  initial begin
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) hs[r] = in_valid[r] & in_ready[r];
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (rd_p[r] < wr_p[r] && (hs[r] || fbuf[r][rd_p[r]][8])) rd_p[r]++;
        in_valid[r] = (rd_p[r] < wr_p[r]) && !fbuf[r][rd_p[r]][8];
        in_data[r*DW +: DW] = (rd_p[r] < wr_p[r]) ? fbuf[r][rd_p[r]][7:0] : 8'h00;
      end
      res_ready = toggle_mode ? ~res_ready : 1'b1;
    end
  end

  // Engine model: computes valid conv1d outputs from whatever was written to its BRAMs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done_m = 1'b0;
      if (eng_timer > 0) begin
        eng_timer--;
        if (eng_timer == 0) begin
          for (int i = 0; i < OL; i++) begin
            int s;
            s = 0;
            for (int k = 0; k < KS; k++)
              s += int'($signed(dmem[i+k])) * int'($signed(wmem[k]));
            rmem[i] = 24'(s);
          end
          done_m = 1'b1;
        end
      end
    end
  end

  // Monitor: engine writes, start pulses, handshake rules and the result scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_start = 1'b0;
      end else begin
        chk($countones(in_ready) <= 1, "in_ready_onehot", 64'(in_ready), 64'd1);
`ifndef CONV_SCHED_WATCHDOG_EN
        chk(err == 1'b0, "err_tied_low", 64'(err), 64'd0);
`endif
        if (dwen) begin
          chk(daddr == ADW'(dcnt), "data_addr", 64'(daddr), 64'(dcnt));
          chk(|(in_valid & in_ready), "data_wen_needs_hs", 64'(in_valid), 64'(in_ready));
          dmem[daddr] = ddin;
          dcnt++;
        end
        if (wwen) begin
          chk(waddr == ADW'(wcnt), "weight_addr", 64'(waddr), 64'(wcnt));
          chk(|(in_valid & in_ready), "weight_wen_needs_hs", 64'(in_valid), 64'(in_ready));
          wmem[waddr] = wdin;
          wcnt++;
        end
        if (eng_start) begin
          chk(!prev_start, "start_one_cycle", 64'(prev_start), 64'd0);
          chk(dcnt == IL && wcnt == KS, "words_before_start", 64'(dcnt*16 + wcnt), 64'(IL*16 + KS));
          dcnt = 0;
          wcnt = 0;
          starts++;
          if (!eng_mute) eng_timer = 4;
        end
        prev_start = eng_start;
        if (prev_stall)
          chk({res_valid, res_id, res_last, res_data} == prev_res, "res_hold_stable",
              64'({res_valid, res_id, res_last, res_data}), 64'(prev_res));
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_result", 64'(res_data), 64'd0);
          end else begin
            res_t e;
            e = sb.pop_front();
            chk(res_data == e.data, "res_data", 64'(res_data), 64'(e.data));
            chk(res_id == e.id, "res_id", 64'(res_id), 64'(e.id));
            chk(res_last == e.last, "res_last", 64'(res_last), 64'(e.last));
          end
        end
        prev_stall = res_valid & ~res_ready;
        prev_res   = {res_valid, res_id, res_last, res_data};
      end
    end
  end

  task automatic queue_job(input job_t j, input bit push_sb);
    int r;
    r = int'(j.id);
    for (int i = 0; i < IL; i++) begin
      if (i == int'(j.gap_at) && j.gap_len != 0)
        for (int b = 0; b < int'(j.gap_len); b++) begin
          fbuf[r][wr_p[r]] = 9'h100;
          wr_p[r]++;
        end
      fbuf[r][wr_p[r]] = {1'b0, j.d[i]};
      wr_p[r]++;
    end
    for (int i = 0; i < KS; i++) begin
      fbuf[r][wr_p[r]] = {1'b0, j.w[i]};
      wr_p[r]++;
    end
    if (push_sb) begin
      for (int i = 0; i < OL; i++) begin
        res_t e;
        e.id   = j.id;
        e.data = j.exp[i];
        e.last = (i == OL - 1);
        sb.push_back(e);
      end
      exp_starts++;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(rd_p[0] == wr_p[0] && rd_p[1] == wr_p[1] && sb.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, name, 64'(n), 64'(budget));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) rd_p[r] = wr_p[r];
    in_valid  = '0;
    in_data   = '0;
    sb.delete();
    dcnt      = 0;
    wcnt      = 0;
    eng_timer = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = '0; in_data = '0; res_ready = 1'b1; toggle_mode = 1'b0;
    eng_mute = 1'b0; force_done = 1'b0; eng_timer = 0; done_m = 1'b0;
    dcnt = 0; wcnt = 0; starts = 0; exp_starts = 0; prev_stall = 1'b0; prev_start = 1'b0;
    prev_res = '0;
    for (int r = 0; r < NR; r++) begin rd_p[r] = 0; wr_p[r] = 0; end
    for (int i = 0; i < 8; i++) rmem[i] = '0;
    for (int i = 0; i < 16; i++) begin dmem[i] = '0; wmem[i] = '0; end

    for (int i = 0; i < IL; i++) begin
      jobs[0].d[i] = 8'(i + 1);
      jobs[1].d[i] = 8'd3;
      jobs[2].d[i] = 8'(10 + i);
      jobs[3].d[i] = 8'h80;
      jobs[4].d[i] = 8'(i + 1);
    end
    jobs[0].w = {8'hFF, 8'h00, 8'h01};
    jobs[1].w = {8'h01, 8'h01, 8'h01};
    jobs[2].w = {8'h00, 8'h00, 8'h02};
    jobs[3].w = {8'h7F, 8'h7F, 8'h7F};
    jobs[4].w = {8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < OL; i++) begin
      jobs[0].exp[i] = 24'hFFFFFE;
      jobs[1].exp[i] = 24'd9;
      jobs[2].exp[i] = 24'(20 + 2 * i);
      jobs[3].exp[i] = 24'hFF4180;
      jobs[4].exp[i] = 24'hFFFFFE;
    end
    jobs[0].id = 1'b0; jobs[0].gap_at = 8'd0; jobs[0].gap_len = 8'd0; jobs[0].toggle = 1'b0;
    jobs[1].id = 1'b1; jobs[1].gap_at = 8'd0; jobs[1].gap_len = 8'd0; jobs[1].toggle = 1'b1;
    jobs[2].id = 1'b0; jobs[2].gap_at = 8'd3; jobs[2].gap_len = 8'd5; jobs[2].toggle = 1'b0;
    jobs[3].id = 1'b1; jobs[3].gap_at = 8'd0; jobs[3].gap_len = 8'd0; jobs[3].toggle = 1'b1;
    jobs[4].id = 1'b0; jobs[4].gap_at = 8'd4; jobs[4].gap_len = 8'd5; jobs[4].toggle = 1'b1;

    repeat (3) @(negedge clk);
    chk(all_out == 64'd0, "reset_outputs_zero", all_out, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk(busy == 1'b0, "idle_after_reset", 64'(busy), 64'd0);

    // Both requesters valid together, twice: service order 0,1 then 0,1.
    for (int round = 0; round < 2; round++) begin
      @(posedge clk);
      #2;
      queue_job(jobs[0], 1'b1);
      queue_job(jobs[1], 1'b1);
      wait_idle(600, "timeout_rr_round");
    end

    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #2;
      toggle_mode = jobs[j].toggle;
      queue_job(jobs[j], 1'b1);
      wait_idle(600, "timeout_table_job");
    end
    toggle_mode = 1'b0;

    // eng_done outside RUN must be ignored.
    @(posedge clk);
    #2;
    force_done = 1'b1;
    @(posedge clk);
    #2;
    force_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk(busy == 1'b0 && res_valid == 1'b0, "done_in_idle_ignored", 64'({busy, res_valid}), 64'd0);
    end

    // Reset while loading weights, then a clean job.
    @(posedge clk);
    #2;
    queue_job(jobs[0], 1'b0);
    n = 0;
    while (n < 200 && wcnt < 1) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(n < 200, "timeout_reach_load_w", 64'(n), 64'd200);
    apply_reset();
    @(negedge clk);
    chk(all_out == 64'd0, "abort_outputs_zero", all_out, 64'd0);
    @(negedge clk);
    chk(all_out == 64'd0, "abort_outputs_stay_zero", all_out, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    queue_job(jobs[0], 1'b1);
    wait_idle(600, "timeout_after_abort");

`ifdef CONV_SCHED_WATCHDOG_EN
    @(posedge clk);
    #2;
    eng_mute = 1'b1;
    queue_job(jobs[0], 1'b0);
    exp_starts++;
    n = 0;
    while (n < 200 && !eng_start) begin
      @(negedge clk);
      n++;
    end
    chk(n < 200, "timeout_wdog_start", 64'(n), 64'd200);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 400);
    chk(n == 256, "wdog_latency", 64'(n), 64'd256);
    @(negedge clk);
    chk(busy == 1'b0 && err == 1'b0, "wdog_back_to_idle", 64'({busy, err}), 64'd0);
    eng_mute = 1'b0;
    @(posedge clk);
    #2;
    queue_job(jobs[1], 1'b1);
    wait_idle(600, "timeout_after_wdog");
`endif

    chk(starts == exp_starts, "start_pulse_count", 64'(starts), 64'(exp_starts));
    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
